// File: rtl/tele_pkg.sv
// Shared definitions for the telephone call protocol FSMs (caller and callee sides).
package tele_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RINGING      = 3'd1,
        CONNECTED    = 3'd2,
        HANGUP       = 3'd3,
        CALL_TIMEOUT = 3'd4,
        MISSED       = 3'd5
    } tele_state_t;

    localparam int RING_LIMIT_DEF = 5;
    localparam int CALL_LIMIT_DEF = 250;

endpackage

// File: rtl/tele_counter.sv
// Up-counter with synchronous clear and increment; flags zero and terminal count (LIMIT-1).
module tele_counter #(
    parameter int LIMIT = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic zero,
    output logic tc
);
    localparam int W = $clog2(LIMIT);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign zero = (count_reg == '0);
    assign tc   = (count_reg == W'(LIMIT - 1));

endmodule

// File: rtl/tele_callee_fsm.sv
// Called-party controller: rings on an incoming call, then connects, rejects or records a miss,
// and bounds the call duration.
module tele_callee_fsm
    import tele_pkg::*;
#(
    parameter int RING_LIMIT = RING_LIMIT_DEF,
    parameter int CALL_LIMIT = CALL_LIMIT_DEF,
    parameter int MISSED_W   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                incoming_call,
    input  logic                answer,
    input  logic                reject,
    input  logic                end_call,
    input  logic                remote_end,
    input  logic                ack,
    input  logic                clr_missed,
    output logic                ringing,
    output logic                pickup_call,
    output logic                in_call,
    output logic                call_timeout,
    output logic                missed_call,
    output logic                call_ended,
    output logic [MISSED_W-1:0] missed_count
);

    tele_state_t         state_reg, state_next;
    logic [MISSED_W-1:0] missed_count_reg;
    logic                ring_zero, ring_tc;
    logic                call_zero, call_tc;
    logic                in_ringing, in_connected;

    assign in_ringing   = (state_reg == RINGING);
    assign in_connected = (state_reg == CONNECTED);

    // Each counter runs only in its own state, so it reads 0 on that state's entry cycle.
    tele_counter #(.LIMIT(RING_LIMIT)) u_ring_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (!in_ringing),
        .inc     (in_ringing),
        .zero    (ring_zero),
        .tc      (ring_tc)
    );

    tele_counter #(.LIMIT(CALL_LIMIT)) u_call_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (!in_connected),
        .inc     (in_connected),
        .zero    (call_zero),
        .tc      (call_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ringing      = 1'b0;
        pickup_call  = 1'b0;
        in_call      = 1'b0;
        call_timeout = 1'b0;
        missed_call  = 1'b0;
        call_ended   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (incoming_call) state_next = RINGING;
            end
            RINGING: begin
                ringing = 1'b1;
                // Caller abandoning wins over a simultaneous answer.
                if (!incoming_call)  state_next = MISSED;
                else if (reject)     state_next = IDLE;
                else if (answer)     state_next = CONNECTED;
                else if (ring_tc)    state_next = MISSED;
            end
            CONNECTED: begin
                in_call     = 1'b1;
                pickup_call = call_zero;
                if (end_call || remote_end) state_next = HANGUP;
                else if (call_tc)           state_next = CALL_TIMEOUT;
            end
            HANGUP: begin
                call_ended = 1'b1;
                state_next = IDLE;
            end
            CALL_TIMEOUT: begin
                call_timeout = 1'b1;
                if (ack) state_next = IDLE;
            end
            MISSED: begin
                missed_call = 1'b1;
                if (ack) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Count on the entering edge only; a clear on the same edge wins.
    always_ff @(posedge clk) begin
        if (!reset_n || clr_missed) begin
            missed_count_reg <= '0;
        end else if (state_next == MISSED && state_reg != MISSED && missed_count_reg != '1) begin
            missed_count_reg <= missed_count_reg + 1'b1;
        end
    end

    assign missed_count = missed_count_reg;

    // ring_zero is kept for symmetry with the call counter; fold it in harmlessly.
    logic unused_ring_zero;
    assign unused_ring_zero = ring_zero;

endmodule

// File: tb/tb_tele_callee_fsm.sv
// Directed bench for tele_callee_fsm: expected outputs are queued per cycle and checked after each edge.
module tb_tele_callee_fsm;

    logic       clk = 1'b0;
    logic       reset_n, incoming_call, answer, reject, end_call, remote_end, ack, clr_missed;
    logic       ringing, pickup_call, in_call, call_timeout, missed_call, call_ended;
    logic [3:0] missed_count;

    int checks   = 0;
    int failures = 0;

    logic [9:0] sb_q[$];
    string      tag_q[$];

    // Output vector order: {ringing, pickup, in_call, timeout, missed, ended}
    localparam logic [5:0] Z  = 6'b000000;
    localparam logic [5:0] R  = 6'b100000;
    localparam logic [5:0] PC = 6'b011000;
    localparam logic [5:0] C  = 6'b001000;
    localparam logic [5:0] T  = 6'b000100;
    localparam logic [5:0] M  = 6'b000010;
    localparam logic [5:0] E  = 6'b000001;

    tele_callee_fsm #(.RING_LIMIT(5), .CALL_LIMIT(250), .MISSED_W(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .incoming_call (incoming_call),
        .answer        (answer),
        .reject        (reject),
        .end_call      (end_call),
        .remote_end    (remote_end),
        .ack           (ack),
        .clr_missed    (clr_missed),
        .ringing       (ringing),
        .pickup_call   (pickup_call),
        .in_call       (in_call),
        .call_timeout  (call_timeout),
        .missed_call   (missed_call),
        .call_ended    (call_ended),
        .missed_count  (missed_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic [5:0] exp_o, input logic [3:0] exp_mc, input string tag);
        logic [9:0] exp_v, obs_v;
        string      t;
        sb_q.push_back({exp_o, exp_mc});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        t     = tag_q.pop_front();
        obs_v = {ringing, pickup_call, in_call, call_timeout, missed_call, call_ended, missed_count};
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", t, obs_v, exp_v);
        end
    endtask

    initial begin
        logic [3:0] mc;
        reset_n = 1'b0; incoming_call = 1'b0; answer = 1'b0; reject = 1'b0;
        end_call = 1'b0; remote_end = 1'b0; ack = 1'b0; clr_missed = 1'b0;

        tick(Z, 4'd0, "reset0");
        tick(Z, 4'd0, "reset1");
        reset_n = 1'b1;
        tick(Z, 4'd0, "idle_after_reset");

        // Ring timeout: exactly 5 ringing cycles, then MISSED with count 1
        incoming_call = 1'b1;
        for (int i = 0; i < 5; i++) tick(R, 4'd0, "ring_timeout_ringing");
        tick(M, 4'd1, "ring_timeout_missed");
        tick(M, 4'd1, "missed_ignores_incoming");
        incoming_call = 1'b0; ack = 1'b1;
        tick(Z, 4'd1, "missed_ack_idle");
        ack = 1'b0;

        // Reset mid-call: no call_ended pulse, count cleared
        incoming_call = 1'b1;
        tick(R, 4'd1, "rst_call_ring");
        answer = 1'b1;
        tick(PC, 4'd1, "rst_call_pickup");
        answer = 1'b0; incoming_call = 1'b0;
        tick(C, 4'd1, "rst_call_in_call");
        reset_n = 1'b0;
        tick(Z, 4'd0, "rst_mid_call0");
        tick(Z, 4'd0, "rst_mid_call1");
        reset_n = 1'b1;
        tick(Z, 4'd0, "rst_mid_call_release");

        // Answered call with local hangup
        incoming_call = 1'b1;
        tick(R, 4'd0, "answer_ring1");
        tick(R, 4'd0, "answer_ring2");
        tick(R, 4'd0, "answer_ring3");
        answer = 1'b1;
        tick(PC, 4'd0, "answer_pickup");
        answer = 1'b0; incoming_call = 1'b0;
        for (int i = 0; i < 9; i++) tick(C, 4'd0, "answer_in_call");
        end_call = 1'b1;
        tick(E, 4'd0, "answer_call_ended");
        end_call = 1'b0;
        tick(Z, 4'd0, "answer_back_idle");

        // Caller abandons on the same edge as answer
        incoming_call = 1'b1;
        tick(R, 4'd0, "abandon_ring1");
        tick(R, 4'd0, "abandon_ring2");
        incoming_call = 1'b0; answer = 1'b1;
        tick(M, 4'd1, "abandon_missed");
        answer = 1'b0; ack = 1'b1;
        tick(Z, 4'd1, "abandon_ack");
        ack = 1'b0;

        // Reject is not a miss
        incoming_call = 1'b1;
        tick(R, 4'd1, "reject_ring");
        reject = 1'b1;
        tick(Z, 4'd1, "reject_idle");
        reject = 1'b0; incoming_call = 1'b0;
        tick(Z, 4'd1, "reject_stay_idle");

        // Call timeout after 250 in_call cycles; hold until ack
        incoming_call = 1'b1;
        tick(R, 4'd1, "timeout_ring");
        answer = 1'b1;
        tick(PC, 4'd1, "timeout_pickup");
        answer = 1'b0; incoming_call = 1'b0; ack = 1'b1;
        for (int i = 0; i < 249; i++) tick(C, 4'd1, "timeout_in_call");
        ack = 1'b0;
        tick(T, 4'd1, "timeout_enter");
        end_call = 1'b1;
        tick(T, 4'd1, "timeout_hold");
        end_call = 1'b0; ack = 1'b1;
        tick(Z, 4'd1, "timeout_ack");
        ack = 1'b0;

        // Hangup on the last allowed cycle beats timeout
        incoming_call = 1'b1;
        tick(R, 4'd1, "corner_ring");
        answer = 1'b1;
        tick(PC, 4'd1, "corner_pickup");
        answer = 1'b0; incoming_call = 1'b0;
        for (int i = 0; i < 249; i++) tick(C, 4'd1, "corner_in_call");
        remote_end = 1'b1;
        tick(E, 4'd1, "corner_hangup");
        remote_end = 1'b0;
        tick(Z, 4'd1, "corner_idle");

        // Saturation and clear
        clr_missed = 1'b1;
        tick(Z, 4'd0, "clr_in_idle");
        clr_missed = 1'b0;
        mc = 4'd0;
        for (int k = 0; k < 17; k++) begin
            incoming_call = 1'b1;
            tick(R, mc, "sat_ring");
            incoming_call = 1'b0;
            if (mc != 4'd15) mc = mc + 4'd1;
            tick(M, mc, "sat_missed");
            ack = 1'b1;
            tick(Z, mc, "sat_ack");
            ack = 1'b0;
        end
        incoming_call = 1'b1;
        tick(R, 4'd15, "clr_ring18");
        incoming_call = 1'b0; clr_missed = 1'b1;
        tick(M, 4'd0, "clr_beats_inc");
        clr_missed = 1'b0; ack = 1'b1;
        tick(Z, 4'd0, "clr_ack");
        ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tele_callee_fsm.md
Name: tele_callee_fsm

Overview:
Called-party (receiving end) controller of the telephone call protocol; the counterpart of the caller-side dial FSM.
- Detects an incoming call, rings for a bounded number of cycles, and accepts, rejects or misses the call.
- Tracks call duration and reports hangup and timeout.
- Its pickup_call output drives the caller side's pickup_call input; its in_call and missed-call status feed the handset UI.

Parameters:
RING_LIMIT, 5, maximum cycles spent in RINGING before the call is declared missed (>=2)
CALL_LIMIT, 250, maximum cycles spent in CONNECTED before call timeout (>=2)
MISSED_W, 4, width of the saturating missed-call counter

Ports:
clk  input  1  single clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
incoming_call  input  1  level; high while the caller is dialing this party
answer  input  1  local user accepts the ringing call
reject  input  1  local user declines the ringing call
end_call  input  1  local user hangs up
remote_end  input  1  caller hangs up
ack  input  1  user acknowledges a missed-call or timeout indication
clr_missed  input  1  clears missed_count
ringing  output  1  high in RINGING
pickup_call  output  1  one-cycle pulse on the first CONNECTED cycle
in_call  output  1  high in CONNECTED
call_timeout  output  1  high in CALL_TIMEOUT
missed_call  output  1  high in MISSED
call_ended  output  1  one-cycle pulse in HANGUP
missed_count  output  MISSED_W  number of missed calls, saturating

Behaviour:
- Reset: sampled only on a rising clk edge with reset_n low.
  - State goes to IDLE; counters and missed_count go to 0.
  - All 1-bit outputs are 0 from the first cycle after that edge.
  - Reset asserted mid-call or mid-ring aborts the call with no call_ended pulse.
- Outputs:
  - Moore-decoded from the state register and counters; no combinational input-to-output path.
  - pickup_call = (state==CONNECTED) && (call_cnt==0).
- Counters:
  - ring_cnt is $clog2(RING_LIMIT) bits; call_cnt is $clog2(CALL_LIMIT) bits.
  - Each counter is cleared in every state except its own, increments by 1 per cycle in its own state, and is 0 on the entry cycle.
- IDLE: incoming_call -> RINGING; otherwise stay.
- RINGING, priority high to low:
  1. !incoming_call (caller abandoned) -> MISSED.
  2. reject -> IDLE. This is not a miss.
  3. answer -> CONNECTED.
  4. ring_cnt==RING_LIMIT-1 -> MISSED.
  5. Otherwise stay.
  - RINGING therefore lasts at most RING_LIMIT cycles.
- CONNECTED, priority high to low:
  1. end_call | remote_end -> HANGUP. Hangup beats timeout on the same cycle.
  2. call_cnt==CALL_LIMIT-1 -> CALL_TIMEOUT.
  3. Otherwise stay.
  - in_call is high for at most CALL_LIMIT cycles.
- HANGUP: exactly one cycle with call_ended=1, then -> IDLE unconditionally.
- CALL_TIMEOUT: hold with call_timeout=1 until ack -> IDLE.
- MISSED: hold with missed_call=1 until ack -> IDLE.
  - A new incoming_call is ignored until ack; it is not counted.
- missed_count:
  - Increments by 1 on the clock edge that enters MISSED.
  - Saturates at 2^MISSED_W-1.
  - clr_missed sets it to 0 and takes priority over an increment on the same edge.
  - It is not cleared by ack.
- Inputs not listed for a state are ignored in that state, e.g. answer in IDLE, ack in CONNECTED.
- Unused state encodings -> IDLE on the next edge, with all outputs 0.

Decomposition:
- Shared package tele_pkg:
  - 3-bit state encodings IDLE, RINGING, CONNECTED, HANGUP, CALL_TIMEOUT, MISSED.
  - Default limits RING_LIMIT_DEF=5 and CALL_LIMIT_DEF=250, shared with the caller-side FSM.
- One natural sub-module, tele_counter: a parameterised up-counter with synchronous clear, increment and terminal-count flag.
  - Instantiated twice, for ring and call duration.

Test Plan:
- Reset: reset_n low for 2 edges while in CONNECTED -> state IDLE, all outputs 0, missed_count=0, and no call_ended pulse.
- Answered call, local hangup:
  - Stimulus: incoming_call=1, answer on the 3rd RINGING cycle, end_call 10 cycles later.
  - Response: ringing for 3 cycles, then pickup_call pulses for exactly 1 cycle, in_call high for 10 cycles, then call_ended for 1 cycle, then IDLE.
- Ring timeout: incoming_call held with no answer -> ringing for exactly 5 cycles, then missed_call=1 and missed_count=1; after ack, IDLE.
- Caller abandons: incoming_call drops on RINGING cycle 2 at the same edge as answer -> MISSED, not CONNECTED; missed_count increments.
- Call timeout:
  - Stimulus: answer, then no hangup.
  - Response: in_call for exactly 250 cycles, then call_timeout holds until ack.
  - Corner: end_call on cycle 250 -> HANGUP instead of CALL_TIMEOUT.
- Saturation and clear: 17 consecutive missed calls with MISSED_W=4 -> missed_count saturates at 15; clr_missed on the edge of an 18th miss -> 0.
